// File: rtl/cbrt_mul_unit.sv
// Sequential unit computing y = a * floor(cbrt(b)), or floor(cbrt(b)) alone when mode=1.
// Bit-serial restoring cube root (one result bit per cycle), then an LSB-first shift-add multiply.
module cbrt_mul_unit #(
    parameter int A_W   = 8,
    parameter int B_W   = 32,
    parameter int CNT_W = 8
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            start,
    input  logic                            mode,
    input  logic                            abort,
    input  logic [A_W-1:0]                  a,
    input  logic [B_W-1:0]                  b,
    output logic                            busy,
    output logic                            done,
    output logic [A_W+(B_W+2)/3-1:0]        result,
    output logic [CNT_W-1:0]                done_cnt
);

    localparam int N   = (B_W + 2) / 3;
    localparam int R_W = A_W + N;
    localparam int X_W = 3 * N;
    // The trial subtrahend can exceed the 3N-bit remainder, so compare at extra width.
    localparam int T_W = 3 * N + 4;
    localparam int I_W = (N > 1) ? $clog2(N) : 1;
    localparam int C_W = $clog2(A_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        ROOT,
        MUL
    } state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [A_W-1:0]   a_q, a_d;
    logic [N-1:0]     y_q, y_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [I_W-1:0]   i_q, i_d;
    logic [R_W-1:0]   mcand_q, mcand_d;
    logic [R_W-1:0]   acc_q, acc_d;
    logic [C_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [R_W-1:0]   result_q, result_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

    logic [N-1:0]     y2;
    logic [T_W-1:0]   term;
    logic [T_W-1:0]   t;
    logic [T_W-1:0]   x_ext;
    logic [N-1:0]     y_step;
    logic [X_W-1:0]   x_step;
    logic [R_W-1:0]   partial;
    logic [R_W-1:0]   acc_sum;

    always_comb begin
        y2     = y_q << 1;
        term   = T_W'(3) * T_W'(y2) * (T_W'(y2) + T_W'(1)) + T_W'(1);
        t      = term << (T_W'(i_q) * T_W'(3));
        x_ext  = T_W'(x_q);
        y_step = y2;
        x_step = x_q;
        if (x_ext >= t) begin
            x_step = X_W'(x_ext - t);
            y_step = y2 | N'(1);
        end
        partial = a_q[0] ? mcand_q : '0;
        acc_sum = acc_q + partial;
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        a_d        = a_q;
        y_d        = y_q;
        x_d        = x_q;
        i_d        = i_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        bit_cnt_d  = bit_cnt_q;
        result_d   = result_q;
        done_d     = 1'b0;
        done_cnt_d = done_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    a_d     = a;
                    y_d     = '0;
                    x_d     = X_W'(b);
                    i_d     = I_W'(N - 1);
                    state_d = ROOT;
                end
            end
            ROOT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    x_d = x_step;
                    y_d = y_step;
                    i_d = i_q - I_W'(1);
                    if (i_q == '0) begin
                        if (mode_q) begin
                            result_d   = R_W'(y_step);
                            done_d     = 1'b1;
                            done_cnt_d = done_cnt_q + CNT_W'(1);
                            state_d    = IDLE;
                        end else begin
                            mcand_d   = R_W'(y_step);
                            acc_d     = '0;
                            bit_cnt_d = '0;
                            state_d   = MUL;
                        end
                    end
                end
            end
            MUL: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    acc_d     = acc_sum;
                    a_d       = a_q >> 1;
                    mcand_d   = mcand_q << 1;
                    bit_cnt_d = bit_cnt_q + C_W'(1);
                    if (bit_cnt_q == C_W'(A_W - 1)) begin
                        result_d   = acc_sum;
                        done_d     = 1'b1;
                        done_cnt_d = done_cnt_q + CNT_W'(1);
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            a_q        <= '0;
            y_q        <= '0;
            x_q        <= '0;
            i_q        <= '0;
            mcand_q    <= '0;
            acc_q      <= '0;
            bit_cnt_q  <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            a_q        <= a_d;
            y_q        <= y_d;
            x_q        <= x_d;
            i_q        <= i_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            bit_cnt_q  <= bit_cnt_d;
            result_q   <= result_d;
            done_q     <= done_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign result   = result_q;
    assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_cbrt_mul_unit.sv
// Directed bench for cbrt_mul_unit: expected results are queued at start and
// compared by a done monitor; a second instance with a 2-bit counter checks wrap.
module tb_cbrt_mul_unit;

    localparam int A_W = 8;
    localparam int B_W = 32;
    localparam int N   = (B_W + 2) / 3;
    localparam int R_W = A_W + N;
    localparam int LAT0 = N + A_W;
    localparam int LAT1 = N;

    logic           CLK = 1'b0;
    logic           RST;
    logic           start, mode, abort;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic           busy, done;
    logic [R_W-1:0] result;
    logic [7:0]     done_cnt;

    logic           start2, busy2, done2;
    logic [R_W-1:0] result2;
    logic [1:0]     done_cnt2;

    int checks = 0;
    int errors = 0;
    longint unsigned exp_q[$];
    logic [7:0] exp_cnt = '0;

    always #5 CLK = ~CLK;

    cbrt_mul_unit #(.A_W(A_W), .B_W(B_W), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .start(start), .mode(mode), .abort(abort),
        .a(a), .b(b), .busy(busy), .done(done), .result(result), .done_cnt(done_cnt)
    );

    cbrt_mul_unit #(.A_W(A_W), .B_W(B_W), .CNT_W(2)) dut2 (
        .CLK(CLK), .RST(RST), .start(start2), .mode(1'b1), .abort(1'b0),
        .a(8'd0), .b(32'd8), .busy(busy2), .done(done2), .result(result2), .done_cnt(done_cnt2)
    );

    task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned icbrt(input longint unsigned v);
        longint unsigned r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives one accepted start; leaves the bench 1 time unit after the accepting edge.
    task automatic start_op(input logic [A_W-1:0] av, input logic [B_W-1:0] bv,
                            input logic mv, input bit push);
        a = av; b = bv; mode = mv; start = 1'b1;
        if (push) exp_q.push_back(mv ? icbrt(bv) : longint'(av) * icbrt(bv));
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lat);
        int cyc = 0;
        bit seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            cyc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_latency"}, seen ? cyc : -1, lat);
        check({tag, "_busy_at_done"}, busy, 0);
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (RST) begin
            exp_cnt = '0;
        end else if (done) begin
            exp_cnt = exp_cnt + 8'd1;
            if (exp_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                check("result", result, exp_q.pop_front());
                check("done_cnt", done_cnt, exp_cnt);
            end
        end
    end

    initial begin
        RST = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; a = '0; b = '0; start2 = 1'b0;
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_done_cnt", done_cnt, 0);
        tick();
        RST = 1'b0;
        tick();

        // Basic multiply: 5 * cbrt(9) = 10
        start_op(8'd5, 32'd9, 1'b0, 1'b1);
        check("t1_busy_after_start", busy, 1);
        wait_done("t1", LAT0);
        tick();
        check("t1_done_one_cycle", done, 0);

        // Back-to-back: start held during the first done cycle
        start_op(8'd7, 32'd16, 1'b0, 1'b1);
        wait_done("t2a", LAT0);
        start_op(8'd255, 32'hFFFF_FFFF, 1'b0, 1'b1);
        check("t2_no_idle_gap", busy, 1);
        check("t2_done_dropped", done, 0);
        wait_done("t2b", LAT0);
        check("t2_max_result", result, 414375);
        tick();

        // Root-only mode, a ignored
        start_op(8'd99, 32'd1000, 1'b1, 1'b1);
        wait_done("t3a", LAT1);
        tick();
        start_op(8'd99, 32'd27, 1'b1, 1'b1);
        wait_done("t3b", LAT1);
        tick();
        start_op(8'd99, 32'd0, 1'b1, 1'b1);
        wait_done("t3c", LAT1);
        tick();

        // Abort on cycle 5, then a fresh op
        start_op(8'd5, 32'd9, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_busy_after_abort", busy, 0);
        check("t4_result_held", result, 0);
        check("t4_cnt_held", done_cnt, 6);
        tick();
        start_op(8'd3, 32'd64, 1'b0, 1'b1);
        wait_done("t4", LAT0);
        tick();

        // a=0 still takes full latency
        start_op(8'd0, 32'd125, 1'b0, 1'b1);
        wait_done("t5_a0", LAT0);
        tick();

        // start while busy is ignored: 2 * cbrt(27) = 6
        start_op(8'd2, 32'd27, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) tick();
        a = 8'd9; b = 32'd1000; mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t6_ignored_start", LAT0 - 4);
        tick();

        // Reset asserted mid-MUL
        start_op(8'd6, 32'd100, 1'b0, 1'b0);
        for (int k = 0; k < 14; k++) tick();
        check("t7_busy_before_rst", busy, 1);
        RST = 1'b1;
        #1;
        check("t7_busy", busy, 0);
        check("t7_result", result, 0);
        check("t7_done_cnt", done_cnt, 0);
        exp_q.delete();
        tick();
        RST = 1'b0;
        tick();
        start_op(8'd4, 32'd8, 1'b0, 1'b1);
        wait_done("t7_after_rst", LAT0);
        tick();

        // 2-bit counter wraps: 1, 2, 3, 0, 1
        for (int n = 0; n < 5; n++) begin
            bit seen2 = 1'b0;
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            for (int k = 0; k < 30; k++) begin
                tick();
                if (done2) begin
                    seen2 = 1'b1;
                    break;
                end
            end
            check("t8_done_seen", seen2, 1);
            check("t8_result", result2, 2);
            check("t8_done_cnt", done_cnt2, (n + 1) % 4);
        end

        tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
